// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen
//   Front-panel button conditioner. Each raw active-high button is passed
//   through a two-flop synchroniser, then a per-button FSM that debounces
//   press and release independently and emits one single-cycle pulse per
//   qualified press, with optional auto-repeat while the button stays held.
//
// Ports
//   clk    in   1      system clock, all logic on the rising edge
//   rst_n  in   1      asynchronous active-low reset
//   btn    in   N_BTN  raw asynchronous button levels, 1 = pressed
//   bto    out  N_BTN  registered one-cycle press pulses, one bit per button
//
// Parameters
//   N_BTN       number of buttons
//   DEB_CYCLES  stable samples needed to qualify a press or a release (>=1)
//   RPT_DELAY   cycles from the press pulse to the first repeat pulse
//   RPT_PERIOD  cycles between later repeat pulses; 0 disables auto-repeat

module btn_pulse_gen #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned RPT_DELAY  = 50000000,
    parameter int unsigned RPT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] bto
);

    localparam int unsigned MAX_A = (DEB_CYCLES > RPT_DELAY) ? DEB_CYCLES : RPT_DELAY;
    localparam int unsigned MAX_V = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
    localparam int unsigned CW    = $clog2(64'(MAX_V) + 64'd1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEB_C = cnt_t'(DEB_CYCLES);
    localparam cnt_t DLY_C = cnt_t'(RPT_DELAY);
    localparam cnt_t PER_C = cnt_t'(RPT_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HELD,
        REL
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= btn;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t      state;
        cnt_t        cnt;
        cnt_t        rcnt;
        logic        rpt_phase;
        logic        pulse;
        cnt_t        cnt_inc;
        cnt_t        rcnt_inc;
        cnt_t        rlimit;
        logic [CW:0] rnext;

        // Saturating increments; one extra bit on rnext keeps the compare
        // exact even when rcnt sits at its terminal value.
        always_comb begin
            cnt_inc  = (cnt == '1) ? cnt : cnt + cnt_t'(1);
            rcnt_inc = (rcnt == '1) ? rcnt : rcnt + cnt_t'(1);
            rlimit   = rpt_phase ? PER_C : DLY_C;
            rnext    = {1'b0, rcnt} + (CW+1)'(1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                rpt_phase <= 1'b0;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s[i]) begin
                            state <= ARM;
                            cnt   <= cnt_t'(1);
                        end
                    end
                    ARM: begin
                        if (!s[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DEB_C) begin
                            state     <= HELD;
                            pulse     <= 1'b1;
                            rcnt      <= '0;
                            rpt_phase <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD: begin
                        if (!s[i]) begin
                            state <= REL;
                            cnt   <= cnt_t'(1);
                        end else if (RPT_PERIOD != 0) begin
                            // A pulse cycle suppresses a pulse on the next
                            // cycle; the timer keeps running so the deferred
                            // pulse lands one cycle later.
                            if (rnext >= {1'b0, rlimit} && !pulse) begin
                                pulse     <= 1'b1;
                                rcnt      <= '0;
                                rpt_phase <= 1'b1;
                            end else begin
                                rcnt <= rcnt_inc;
                            end
                        end
                    end
                    REL: begin
                        if (s[i]) begin
                            state     <= HELD;
                            rcnt      <= '0;
                            rpt_phase <= 1'b0;
                        end else if (cnt == DEB_C) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign bto[i] = pulse;
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen
//   Directed bench for btn_pulse_gen with DEB_CYCLES=4, RPT_DELAY=10.
//   dut uses RPT_PERIOD=3; dut0 uses RPT_PERIOD=0 (auto-repeat disabled).
//   Pulses of both instances are logged per bit ({bto0, bto}) with the
//   cycle index at which they were seen.

module tb_btn_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] bto;
    logic [3:0] btn0;
    logic [3:0] bto0;

    btn_pulse_gen #(
        .N_BTN      (4),
        .DEB_CYCLES (4),
        .RPT_DELAY  (10),
        .RPT_PERIOD (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .bto   (bto)
    );

    btn_pulse_gen #(
        .N_BTN      (4),
        .DEB_CYCLES (4),
        .RPT_DELAY  (10),
        .RPT_PERIOD (0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn0),
        .bto   (bto0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned pcount [8];
    int unsigned ptime  [8][4];
    int unsigned consec;
    logic [7:0]  first_vec;
    logic [7:0]  prev;
    logic [7:0]  obs;
    int unsigned t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance at the rising edge, log outputs at the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        obs = {bto0, bto};
        for (int i = 0; i < 8; i++) begin
            if (obs[i]) begin
                if (pcount[i] < 4) ptime[i][pcount[i]] = cyc;
                pcount[i]++;
                if (prev[i]) consec++;
            end
        end
        if (obs != 8'h00 && first_vec == 8'h00) first_vec = obs;
        prev = obs;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_log();
        for (int i = 0; i < 8; i++) begin
            pcount[i] = 0;
            for (int j = 0; j < 4; j++) ptime[i][j] = 0;
        end
        consec    = 0;
        first_vec = 8'h00;
    endtask

    task automatic wait_pulse(input string tag, input int b, input int lim);
        int n;
        n = 0;
        while (pcount[b] == 0 && n < lim) begin
            step();
            n++;
        end
        check(tag, 32'(pcount[b] > 0), 32'd1);
    endtask

    function automatic int unsigned others(input int b);
        int unsigned sum;
        sum = 0;
        for (int i = 0; i < 8; i++) if (i != b) sum += pcount[i];
        return sum;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        prev  = 8'h00;
        obs   = 8'h00;
        t0    = 0;
        clear_log();
        rst_n = 1'b0;
        btn   = 4'b0000;
        btn0  = 4'b0000;

        // Reset state
        steps(3);
        check("reset_bto", 32'(bto), 32'd0);
        check("reset_bto0", 32'(bto0), 32'd0);
        rst_n = 1'b1;
        steps(3);

        // Clean press with auto-repeat
        clear_log();
        t0 = cyc + 1;
        btn[2] = 1'b1;
        steps(20);
        btn[2] = 1'b0;
        steps(15);
        check("clean_count", pcount[2], 32'd3);
        check("clean_latency", ptime[2][0] - t0, 32'd6);
        check("clean_rpt1", ptime[2][1] - ptime[2][0], 32'd10);
        check("clean_rpt2", ptime[2][2] - ptime[2][0], 32'd13);
        check("clean_others", others(2), 32'd0);
        check("clean_consec", consec, 32'd0);

        // Bouncing press never qualifies
        clear_log();
        btn[0] = 1'b1; step();
        btn[0] = 1'b0; step();
        btn[0] = 1'b1; step();
        btn[0] = 1'b0; step();
        btn[0] = 1'b1; steps(3);
        btn[0] = 1'b0; steps(15);
        check("bounce_total", others(8), 32'd0);

        // Release bounce: no second pulse, then a fresh press behaves normally
        clear_log();
        t0 = cyc + 1;
        btn[1] = 1'b1;
        wait_pulse("relb_wait", 1, 20);
        btn[1] = 1'b0; step();
        btn[1] = 1'b1; steps(2);
        btn[1] = 1'b0; steps(20);
        check("relb_count", pcount[1], 32'd1);
        check("relb_latency", ptime[1][0] - t0, 32'd6);
        clear_log();
        t0 = cyc + 1;
        btn[1] = 1'b1;
        steps(8);
        btn[1] = 1'b0;
        steps(10);
        check("fresh_count", pcount[1], 32'd1);
        check("fresh_latency", ptime[1][0] - t0, 32'd6);
        check("fresh_others", others(1), 32'd0);

        // Simultaneous press of three buttons
        clear_log();
        t0 = cyc + 1;
        btn = 4'b1011;
        steps(8);
        btn = 4'b0000;
        steps(12);
        check("simul_vec", 32'(first_vec), 32'h0B);
        check("simul_lat0", ptime[0][0] - t0, 32'd6);
        check("simul_lat1", ptime[1][0] - t0, 32'd6);
        check("simul_lat3", ptime[3][0] - t0, 32'd6);
        check("simul_cnt", pcount[0] + pcount[1] + pcount[3], 32'd3);
        check("simul_bit2", pcount[2], 32'd0);
        check("simul_consec", consec, 32'd0);

        // Reset in the middle of debounce, button held through reset release
        clear_log();
        btn[3] = 1'b1;
        steps(4);
        rst_n = 1'b0;
        #1;
        check("rst_arm_bto", 32'(bto), 32'd0);
        steps(2);
        check("rst_arm_nopulse", others(8), 32'd0);
        clear_log();
        t0 = cyc + 1;
        rst_n = 1'b1;
        wait_pulse("rst_wait", 3, 20);
        check("rst_latency", ptime[3][0] - t0, 32'd6);
        check("pre_rst_bto", 32'(bto), 32'h8);
        rst_n = 1'b0;
        #1;
        check("rst_clear_bto", 32'(bto), 32'd0);
        step();
        rst_n = 1'b1;
        btn = 4'b0000;
        steps(10);

        // Auto-repeat disabled instance
        clear_log();
        t0 = cyc + 1;
        btn0[2] = 1'b1;
        steps(100);
        btn0[2] = 1'b0;
        steps(10);
        check("norpt_count", pcount[6], 32'd1);
        check("norpt_latency", ptime[6][0] - t0, 32'd6);
        check("norpt_others", others(6), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
